pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 104, payload width in bits.
REQ-002 SHALL have parameter CTRL_W, default 8, low payload bits forming the control field (mem_write, reg_write, s_npc...), 0 < CTRL_W <= WIDTH.
REQ-003 SHALL have parameter SKID, default 0: 0 = single entry, 1 = main entry plus skid entry.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream payload valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes payload this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-012 SHALL have port stall  input  1  hazard unit blocks acceptance.
REQ-013 SHALL have port flush  input  1  hazard unit discards all held payloads.
REQ-014 SHALL have port level  output  2  entries held (0..1 for SKID=0, 0..2 for SKID=1).

Function
REQ-015 Transfer in SHALL occur on a rising edge with in_valid && in_ready; transfer out with out_valid && out_ready.
REQ-016 SKID=0: in_ready SHALL equal !stall && !flush && (!out_valid || out_ready), combinational; latency in->out 1 cycle.
REQ-017 SKID=1: in_ready SHALL equal !stall && !flush && !skid_valid, skid_valid being a flop; no combinational path from out_ready to in_ready.
REQ-018 SKID=1: accepted payload SHALL load main if main empty or draining this cycle, otherwise load skid.
REQ-019 SKID=1: when main drains and skid is full, skid SHALL move to main on the same edge; order strictly FIFO.
REQ-020 Stall SHALL block acceptance only; held payloads SHALL still drain to downstream.
REQ-021 Flush SHALL clear every valid bit and set level to 0 on the next edge, overriding simultaneous transfer-in and drain.
REQ-022 out_data[CTRL_W-1:0] SHALL read 0 whenever out_valid=0 (bubble carries no side effects); upper bits SHALL hold last value.
REQ-023 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-024 level SHALL be registered and SHALL change by at most 1 per cycle except on flush.
REQ-025 Simultaneous transfer-in and transfer-out with one entry held SHALL keep level unchanged and replace the entry.

Reset
REQ-026 reset=0 SHALL asynchronously clear all valid bits, all payload registers to 0, level to 0, out_valid to 0, out_data to 0.
REQ-027 Reset mid-transfer SHALL discard all held payloads; in_ready SHALL evaluate from the cleared state immediately after release.

Structure
REQ-028 Shared package pipe_pkg SHALL hold the default widths for each stage boundary (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W) and CTRL_W constants.
REQ-029 One sub-module pipe_slot (WIDTH-bit payload plus valid, load/clear inputs, async reset) SHALL be instantiated once per entry.
REQ-030 SKID SHALL select structure via generate; no unused flops for SKID=0.

Verification
REQ-031 Reset: assert reset=0 mid-stream with level=2 -> out_valid=0, level=0, out_data=0 same cycle, before next edge.
REQ-032 Streaming: in_valid=1, out_ready=1, in_data=1,2,3 -> out_data 1,2,3 on consecutive cycles, 1-cycle latency, level=1.
REQ-033 Backpressure SKID=1: out_ready=0, push A,B -> level=2, in_ready=0, out_data=A held; release out_ready -> A then B, no loss or duplicate.
REQ-034 Flush: level=2, flush=1 with in_valid=1 and data 0xFF -> next cycle level=0, out_valid=0, out_data[CTRL_W-1:0]=0, 0xFF never emitted.
REQ-035 Stall: one entry held, stall=1, out_ready=1 -> entry drains, in_ready=0 throughout, level 1 -> 0.
REQ-036 Random valid/ready/stall/flush 10k cycles against scoreboard, both SKID values -> order preserved, no drops except flushed entries.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default payload widths per stage boundary and
// the width of the low control field that must read zero on a bubble.
package pipe_pkg;

  localparam int IF_ID_W    = 64;
  localparam int ID_EX_W    = 104;
  localparam int EX_MEM_W   = 80;
  localparam int MEM_WB_W   = 72;
  localparam int DEF_CTRL_W = 8;

  // Occupancy update for one edge: a simultaneous push and pop leaves it unchanged.
  function automatic logic [1:0] level_step(input logic [1:0] lvl,
                                            input logic       push,
                                            input logic       pop);
    logic [1:0] nxt;
    nxt = lvl;
    if (push && !pop) begin
      nxt = lvl + 2'd1;
    end else if (pop && !push) begin
      nxt = lvl - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a payload register plus its valid bit.
// Clear beats load so a flush always wins over a same-cycle write.
module pipe_slot #(
  parameter int WIDTH = 104
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, stall and flush.
// SKID=1 adds a second entry so in_ready is driven only from flops.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH  = ID_EX_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       level
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  logic             w_push;
  logic             w_pop;
  logic             w_main_valid;
  logic [WIDTH-1:0] w_main_data;
  logic             w_main_load;
  logic             w_main_clear;
  logic [WIDTH-1:0] w_main_d;

  assign w_push = in_valid && in_ready;
  assign w_pop  = w_main_valid && out_ready;

  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_d),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  generate
    if (SKID == 0) begin : g_single
      assign in_ready     = !stall && !flush && (!w_main_valid || out_ready);
      assign w_main_load  = w_push;
      assign w_main_d     = in_data;
      assign w_main_clear = flush || (w_pop && !w_push);
      assign level        = {1'b0, w_main_valid};
    end else begin : g_skid
      logic             w_skid_valid;
      logic [WIDTH-1:0] w_skid_data;
      logic             w_skid_load;
      logic             w_skid_clear;
      logic [1:0]       r_level;

      assign in_ready = !stall && !flush && !w_skid_valid;

      // Main refills from skid first (older), otherwise from the input.
      assign w_main_load  = !flush && ((w_push && (!w_main_valid || w_pop)) ||
                                       (w_pop && w_skid_valid));
      assign w_main_d     = w_skid_valid ? w_skid_data : in_data;
      assign w_main_clear = flush || (w_pop && !w_main_load);
      assign w_skid_load  = w_push && w_main_valid && !w_pop;
      assign w_skid_clear = flush || (w_pop && w_skid_valid);

      pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
      );

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_level <= 2'd0;
        end else if (flush) begin
          r_level <= 2'd0;
        end else begin
          r_level <= level_step(r_level, w_push, w_pop);
        end
      end

      assign level = r_level;
    end
  endgenerate

  // A bubble must not carry control side effects downstream.
  always_comb begin
    out_data = w_main_data;
    if (!w_main_valid) begin
      out_data[CTRL_W-1:0] = '0;
    end
  end

  assign out_valid = w_main_valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: both SKID variants driven with shared inputs and
// compared each cycle against queue-based occupancy models.
module tb_pipe_stage_reg;

  localparam int W  = 16;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         stall;
  logic         flush;

  logic         ir0, ov0, ir1, ov1;
  logic [W-1:0] od0, od1;
  logic [1:0]   lvl0, lvl1;

  pipe_stage_reg #(.WIDTH(W), .CTRL_W(CW), .SKID(0)) dut0 (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .stall(stall), .flush(flush),
    .level(lvl0)
  );

  pipe_stage_reg #(.WIDTH(W), .CTRL_W(CW), .SKID(1)) dut1 (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .stall(stall), .flush(flush),
    .level(lvl1)
  );

  always #5 clk = ~clk;

  // Reference queues: capacity 1 (SKID=0) and 2 (SKID=1), head is what is presented.
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic         s_ir0, s_ir1, s_ov1;
  logic [W-1:0] s_od1;
  logic [1:0]   s_lvl0, s_lvl1;

  typedef struct {
    logic         iv;
    logic [W-1:0] din;
    logic         ordy;
    logic         stl;
    logic         fls;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic [1:0]   e_lvl;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_side(input string tag, input logic ir, input logic ov,
                          input logic [W-1:0] od, input logic [1:0] lvl,
                          input logic e_ir, input int sz, input logic [W-1:0] head);
    chk({tag, "_in_ready"}, ir, e_ir);
    chk({tag, "_out_valid"}, ov, sz != 0);
    chk({tag, "_level"}, lvl, sz);
    if (sz != 0) chk({tag, "_out_data"}, od, head);
    else         chk({tag, "_bubble_ctrl"}, od[CW-1:0], 0);
  endtask

  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                      input logic st, input logic fl);
    logic e_ir0, e_ir1;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    #1;
    e_ir0 = !st && !fl && (exp_q0.size() == 0 || ordy);
    e_ir1 = !st && !fl && (exp_q1.size() < 2);
    chk_side("skid0", ir0, ov0, od0, lvl0, e_ir0, exp_q0.size(),
             exp_q0.size() != 0 ? exp_q0[0] : '0);
    chk_side("skid1", ir1, ov1, od1, lvl1, e_ir1, exp_q1.size(),
             exp_q1.size() != 0 ? exp_q1[0] : '0);
    s_ir0 = ir0; s_lvl0 = lvl0;
    s_ir1 = ir1; s_ov1 = ov1; s_od1 = od1; s_lvl1 = lvl1;
    @(posedge clk);
    if (rst_n) begin
      if (fl) begin
        exp_q0.delete();
        exp_q1.delete();
      end else begin
        if (exp_q0.size() != 0 && ordy) void'(exp_q0.pop_front());
        if (iv && e_ir0) exp_q0.push_back(d);
        if (exp_q1.size() != 0 && ordy) void'(exp_q1.pop_front());
        if (iv && e_ir1) exp_q1.push_back(d);
      end
    end
  endtask

  initial begin
    // SKID=1 vectors: streaming, backpressure, flush with 0xFF pending, stall drain.
    tbl[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
    tbl[1]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 2'd1};
    tbl[2]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 2'd1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 2'd1};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
    tbl[5]  = '{1'b1, 16'h01A1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
    tbl[6]  = '{1'b1, 16'h02B2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h01A1, 2'd1};
    tbl[7]  = '{1'b1, 16'h0333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01A1, 2'd2};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01A1, 2'd2};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h02B2, 2'd1};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
    tbl[11] = '{1'b1, 16'h0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
    tbl[12] = '{1'b1, 16'h0122, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0111, 2'd1};
    tbl[13] = '{1'b1, 16'h00FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0111, 2'd2};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
    tbl[16] = '{1'b1, 16'h0255, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
    tbl[17] = '{1'b1, 16'h0366, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0255, 2'd1};
    tbl[18] = '{1'b1, 16'h0366, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0};
    tbl[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid0", ov0, 0);
    chk("rst_level0", lvl0, 0);
    chk("rst_out_data0", od0, 0);
    chk("rst_out_valid1", ov1, 0);
    chk("rst_level1", lvl1, 0);
    chk("rst_out_data1", od1, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].iv, tbl[i].din, tbl[i].ordy, tbl[i].stl, tbl[i].fls);
      chk($sformatf("tbl%0d_in_ready", i), s_ir1, tbl[i].e_ir);
      chk($sformatf("tbl%0d_out_valid", i), s_ov1, tbl[i].e_ov);
      chk($sformatf("tbl%0d_level", i), s_lvl1, tbl[i].e_lvl);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), s_od1, tbl[i].e_od);
      else             chk($sformatf("tbl%0d_bubble", i), s_od1[CW-1:0], 0);
    end

    // Asynchronous reset with two entries held in the skid variant.
    step(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00B2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_level1", lvl1, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid1", ov1, 0);
    chk("mid_rst_level1", lvl1, 0);
    chk("mid_rst_out_data1", od1, 0);
    chk("mid_rst_out_valid0", ov0, 0);
    chk("mid_rst_level0", lvl0, 0);
    chk("mid_rst_out_data0", od0, 0);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h00C3, 1'b1, 1'b0, 1'b0);
    chk("post_rst_in_ready0", s_ir0, 1);
    chk("post_rst_in_ready1", s_ir1, 1);

    // Stall blocks acceptance but the held entry still drains (single-entry variant).
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h00D4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00E5, 1'b1, 1'b1, 1'b0);
    chk("stall_in_ready0_a", s_ir0, 0);
    chk("stall_level0_a", s_lvl0, 1);
    step(1'b1, 16'h00E5, 1'b1, 1'b1, 1'b0);
    chk("stall_in_ready0_b", s_ir0, 0);
    chk("stall_level0_b", s_lvl0, 0);

    // Random traffic in phases of varying downstream pressure.
    for (int i = 0; i < 10000; i++) begin
      logic iv, ordy, st, fl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (i % 2000 < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 7) == 0);
      fl   = ($urandom_range(0, 63) == 0);
      step(iv, W'($urandom_range(0, 16'hFFFF)), ordy, st, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
